// File: rtl/dstack_if.sv
// Command and operand bundle between dstack_control/ALU (master) and the
// data-stack storage (slave).
interface dstack_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  halt;
  logic [1:0]            movement;
  logic [WORD_WIDTH-1:0] next_top;
  logic                  rotate;
  logic [4:0]            rotate_addr;

  logic [WORD_WIDTH-1:0] top;
  logic [WORD_WIDTH-1:0] second;
  logic [WORD_WIDTH-1:0] third;
  logic [WORD_WIDTH-1:0] rotate_value;
  logic [5:0]            count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output halt, movement, next_top, rotate, rotate_addr,
    input  top, second, third, rotate_value, count, overflow, underflow
  );

  modport slave (
    input  halt, movement, next_top, rotate, rotate_addr,
    output top, second, third, rotate_value, count, overflow, underflow
  );
endinterface

// File: rtl/dstack.sv
// Register-resident shift stack: push/pop/rotate on every clock edge, with an
// occupancy count and registered overflow/underflow fault pulses.
module dstack #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic     clk,
  input  logic     reset,
  dstack_if.slave  bus
);

  typedef enum logic [1:0] {
    MV_HOLD = 2'b00,
    MV_PUSH = 2'b01,
    MV_POP1 = 2'b10,
    MV_POP2 = 2'b11
  } movement_e;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam logic [5:0] FULL = 6'(DEPTH);

  word_t      mem       [DEPTH];
  word_t      mem_nxt   [DEPTH];
  logic [5:0] count_q,   count_nxt;
  logic       overflow_q, overflow_nxt;
  logic       underflow_q, underflow_nxt;
  word_t      rot_sel;

  // Entry selected by rotate_addr; indices past the end read as zero.
  always_comb begin
    rot_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rotate_addr == 5'(i)) rot_sel = mem[i];
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mem_nxt       = mem;
    count_nxt     = count_q;
    overflow_nxt  = 1'b0;
    underflow_nxt = 1'b0;

    if (!bus.halt) begin
      if (bus.rotate) begin
        // count never exceeds DEPTH, so this also rejects k >= DEPTH.
        if ({1'b0, bus.rotate_addr} >= count_q) begin
          underflow_nxt = 1'b1;
        end else begin
          mem_nxt[0] = rot_sel;
          for (int i = 1; i < DEPTH; i++) begin
            if (5'(i) <= bus.rotate_addr) mem_nxt[i] = mem[i-1];
          end
        end
      end else begin
        mem_nxt[0] = bus.next_top;
        case (movement_e'(bus.movement))
          MV_HOLD: ;
          MV_PUSH: begin
            for (int i = 1; i < DEPTH; i++) mem_nxt[i] = mem[i-1];
            if (count_q == FULL) overflow_nxt = 1'b1;
            else                 count_nxt    = count_q + 6'd1;
          end
          MV_POP1: begin
            for (int i = 1; i < DEPTH - 1; i++) mem_nxt[i] = mem[i+1];
            mem_nxt[DEPTH-1] = '0;
            underflow_nxt    = (count_q < 6'd2);
            count_nxt        = (count_q == 6'd0) ? 6'd0 : count_q - 6'd1;
          end
          MV_POP2: begin
            for (int i = 1; i < DEPTH - 2; i++) mem_nxt[i] = mem[i+2];
            mem_nxt[DEPTH-2] = '0;
            mem_nxt[DEPTH-1] = '0;
            underflow_nxt    = (count_q < 6'd3);
            count_nxt        = (count_q < 6'd2) ? 6'd0 : count_q - 6'd2;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the stack is a register file, not a RAM, and readers see entries
      // directly, so every entry is cleared on reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
      count_q     <= count_nxt;
      overflow_q  <= overflow_nxt;
      underflow_q <= underflow_nxt;
    end
  end

  assign bus.top          = mem[0];
  assign bus.second       = mem[1];
  assign bus.third        = mem[2];
  assign bus.rotate_value = rot_sel;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_dstack.sv
// Scoreboard bench for dstack: the driver queues the hand-computed state after
// each command, a monitor compares it on the following falling edge.
module tb_dstack;

  typedef logic [31:0] word_t;

  typedef struct {
    word_t      top;
    word_t      second;
    word_t      third;
    logic [5:0] count;
    logic       ovf;
    logic       unf;
    logic       rv_chk;
    word_t      rv;
    string      name;
  } exp_t;

  localparam logic [1:0] HOLD = 2'b00, PUSH = 2'b01, POP1 = 2'b10, POP2 = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  dstack_if #(.WORD_WIDTH(32)) bus ();

  dstack #(.WORD_WIDTH(32), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input word_t t, input word_t s, input word_t th,
                              input logic [5:0] c, input logic o, input logic u,
                              input logic rc, input word_t rv, input string n);
    exp_t e;
    e.top = t; e.second = s; e.third = th; e.count = c;
    e.ovf = o; e.unf = u; e.rv_chk = rc; e.rv = rv; e.name = n;
    return e;
  endfunction

  task automatic check(input string name, input string field,
                       input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic cmd(input logic h, input logic [1:0] mv, input word_t nt,
                     input logic rot, input logic [4:0] ra, input exp_t e);
    @(negedge clk);
    #1;
    reset           = 1'b0;
    bus.halt        = h;
    bus.movement    = mv;
    bus.next_top    = nt;
    bus.rotate      = rot;
    bus.rotate_addr = ra;
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  // Monitor: state is stable and rotate_addr still holds the last command.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, "top",       bus.top,             mon_e.top);
        check(mon_e.name, "second",    bus.second,          mon_e.second);
        check(mon_e.name, "third",     bus.third,           mon_e.third);
        check(mon_e.name, "count",     32'(bus.count),      32'(mon_e.count));
        check(mon_e.name, "overflow",  32'(bus.overflow),   32'(mon_e.ovf));
        check(mon_e.name, "underflow", 32'(bus.underflow),  32'(mon_e.unf));
        if (mon_e.rv_chk)
          check(mon_e.name, "rotate_value", bus.rotate_value, mon_e.rv);
      end
    end
  end

  initial begin
    bus.halt        = 1'b1;
    bus.movement    = HOLD;
    bus.next_top    = '0;
    bus.rotate      = 1'b0;
    bus.rotate_addr = '0;

    #2 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, "reset"));

    cmd(0, PUSH, 32'h11, 0, 0, mk(32'h11, 0, 0, 1, 0, 0, 1, 32'h11, "push11"));
    cmd(0, PUSH, 32'h22, 0, 0, mk(32'h22, 32'h11, 0, 2, 0, 0, 1, 32'h22, "push22"));
    cmd(0, PUSH, 32'h33, 0, 2, mk(32'h33, 32'h22, 32'h11, 3, 0, 0, 1, 32'h11, "push33"));
    cmd(0, POP2, 32'h55, 0, 0, mk(32'h55, 0, 0, 1, 0, 0, 1, 32'h55, "pop2_ok"));
    cmd(0, POP1, 32'h66, 0, 0, mk(32'h66, 0, 0, 0, 0, 1, 1, 32'h66, "pop1_unf"));

    // Stack becomes 5,4,3,2,1,66
    cmd(0, PUSH, 32'd1, 0, 1, mk(1, 32'h66, 0, 1, 0, 0, 1, 32'h66, "push1"));
    cmd(0, PUSH, 32'd2, 0, 0, mk(2, 1, 32'h66, 2, 0, 0, 0, 0, "push2"));
    cmd(0, PUSH, 32'd3, 0, 0, mk(3, 2, 1, 3, 0, 0, 0, 0, "push3"));
    cmd(0, PUSH, 32'd4, 0, 0, mk(4, 3, 2, 4, 0, 0, 0, 0, "push4"));
    cmd(0, PUSH, 32'd5, 0, 4, mk(5, 4, 3, 5, 0, 0, 1, 1, "push5"));

    // Rotate k=3 -> 2,5,4,3,1,66; out-of-range k=7 leaves it alone
    cmd(0, PUSH, 32'hDEAD, 1, 3, mk(2, 5, 4, 5, 0, 0, 1, 3, "rot3"));
    cmd(0, PUSH, 32'hDEAD, 1, 7, mk(2, 5, 4, 5, 0, 1, 1, 0, "rot7_unf"));
    cmd(0, HOLD, 32'd2, 0, 4, mk(2, 5, 4, 5, 0, 0, 1, 1, "probe4"));
    cmd(0, HOLD, 32'd2, 0, 5, mk(2, 5, 4, 5, 0, 0, 1, 32'h66, "probe5"));
    cmd(0, HOLD, 32'd2, 0, 2, mk(2, 5, 4, 5, 0, 0, 1, 4, "copy_src"));
    cmd(0, PUSH, 32'd4, 0, 2, mk(4, 2, 5, 6, 0, 0, 1, 5, "copy_push"));

    // 4,2,5,4,3,1,66 : rotate 0 is a no-op, hold overwrites top only
    cmd(0, POP2, 32'h99, 1, 0, mk(4, 2, 5, 6, 0, 0, 1, 4, "rot0"));
    cmd(0, HOLD, 32'h77, 0, 6, mk(32'h77, 2, 5, 6, 0, 0, 1, 32'h66, "hold77"));
    cmd(0, HOLD, 32'h0, 1, 5, mk(1, 32'h77, 2, 6, 0, 0, 1, 3, "rot5_edge"));
    cmd(0, HOLD, 32'h0, 1, 6, mk(1, 32'h77, 2, 6, 0, 1, 1, 32'h66, "rot6_unf"));

    // 1,77,2,5,4,3,66 popped down past empty
    cmd(0, POP1, 32'hA1, 0, 5, mk(32'hA1, 2, 5, 5, 0, 0, 1, 32'h66, "pop1"));
    cmd(0, POP2, 32'hB2, 0, 3, mk(32'hB2, 4, 3, 3, 0, 0, 1, 32'h66, "pop2"));
    cmd(0, POP2, 32'hC3, 0, 1, mk(32'hC3, 32'h66, 0, 1, 0, 0, 1, 32'h66, "pop2_at3"));
    cmd(0, POP2, 32'hD4, 0, 1, mk(32'hD4, 0, 0, 0, 0, 1, 1, 0, "pop2_floor"));
    cmd(0, POP1, 32'hE5, 0, 0, mk(32'hE5, 0, 0, 0, 0, 1, 1, 32'hE5, "pop1_empty"));
    cmd(1, PUSH, 32'hFF, 0, 0, mk(32'hE5, 0, 0, 0, 0, 0, 1, 32'hE5, "halt_clr"));

    // Fill to DEPTH with 1..32 on top of E5
    for (int i = 1; i <= 32; i++) begin
      cmd(0, PUSH, word_t'(i), 0, 31,
          mk(word_t'(i),
             (i == 1) ? 32'hE5 : word_t'(i - 1),
             (i == 1) ? 32'h0 : (i == 2) ? 32'hE5 : word_t'(i - 2),
             6'(i), 0, 0, 1,
             (i == 32) ? 32'd1 : (i == 31) ? 32'hE5 : 32'h0, "fill"));
    end
    cmd(0, PUSH, 32'hAA, 0, 31, mk(32'hAA, 32, 31, 32, 1, 0, 1, 2, "push_full"));
    cmd(1, PUSH, 32'hCC, 0, 31, mk(32'hAA, 32, 31, 32, 0, 0, 1, 2, "halt_full"));
    cmd(0, PUSH, 32'hBB, 0, 31, mk(32'hBB, 32'hAA, 32, 32, 1, 0, 1, 3, "push_full2"));
    cmd(0, HOLD, 32'hBB, 0, 31, mk(32'hBB, 32'hAA, 32, 32, 0, 0, 1, 3, "ovf_pulse"));
    cmd(0, HOLD, 32'h0, 1, 31, mk(3, 32'hBB, 32'hAA, 32, 0, 0, 1, 4, "rot31"));

    // Asynchronous reset between edges, right after an accepted push
    @(negedge clk);
    #1;
    bus.halt     = 1'b0;
    bus.movement = PUSH;
    bus.next_top = 32'h10;
    bus.rotate   = 1'b0;
    bus.rotate_addr = 5'd31;
    @(posedge clk);
    #2 reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, "async_reset"));
    cmd(0, PUSH, 32'h20, 0, 31, mk(32'h20, 0, 0, 1, 0, 0, 1, 0, "after_reset"));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dstack.md
# dstack

Data-stack storage for the core: the register-resident shift stack that carries out the movement, next-top, rotate and rotate-address commands from `dstack_control` on every clock edge. It exposes `top`, `second`, `third` and `rotate_value` back to `dstack_control` and the ALU as the operand source for the next instruction. It also keeps an occupancy count and raises overflow and underflow fault pulses for the core's fault logic.

## Interface
Parameters:
- `WORD_WIDTH`, 32, width of one stack entry.
- `DEPTH`, 32, number of entries. Legal range is 4..32, so every 5-bit `rotate_addr` value is meaningful when DEPTH is 32.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `halt`  in  1  when 1, no state changes. All inputs below are ignored.
- `movement`  in  2  stack movement:
  - 00: hold
  - 01: push 1
  - 10: pop 1
  - 11: pop 2
- `next_top`  in  WORD_WIDTH  value written to entry 0 this cycle.
- `rotate`  in  1  rotate command.
- `rotate_addr`  in  5  depth index for rotate, copy and `rotate_value`. Index 0 is the top entry.
- `top`, `second`, `third`  out  WORD_WIDTH  entries 0, 1 and 2, driven combinationally from the registers.
- `rotate_value`  out  WORD_WIDTH  entry[`rotate_addr`], combinational. It is 0 when `rotate_addr` >= DEPTH.
- `count`  out  6  number of valid entries, 0..DEPTH.
- `overflow`  out  1  registered one-cycle pulse.
- `underflow`  out  1  registered one-cycle pulse.

## Operation
- State:
  - entry[0..DEPTH-1]
  - `count`
  - `overflow` and `underflow` registers
- Reset values:
  - all entries 0
  - `count` 0
  - `overflow` 0 and `underflow` 0
  - consequently `top`, `second`, `third` and `rotate_value` read 0.
- `halt`=1: all state holds and both fault flags clear to 0 on that edge.
- `rotate`=1 takes priority and `movement` is ignored. For k = `rotate_addr`:
  - new[0] = old[k]
  - new[i] = old[i-1] for 1 <= i <= k
  - new[i] = old[i] for i > k
  - `count` is unchanged.
  - `next_top` is ignored; entry 0 always takes old[k].
  - k = 0 is a no-op.
  - If k >= `count` or k >= DEPTH: the entries are left unchanged and `underflow` pulses.
- `movement` 00 with `rotate`=0: new[0] = `next_top`; the other entries hold.
- `movement` 01 (push, which also serves copy): new[0] = `next_top`, new[i] = old[i-1].
  - old[DEPTH-1] is lost.
  - If `count` == DEPTH: `count` stays DEPTH and `overflow` pulses. Otherwise `count` increments by 1.
- `movement` 10 (pop 1): new[0] = `next_top`, new[i] = old[i+1] for i >= 1, new[DEPTH-1] = 0.
  - `count` decrements by 1, floored at 0.
  - `underflow` pulses if `count` < 2 before the edge.
- `movement` 11 (pop 2): new[0] = `next_top`, new[i] = old[i+2] for i >= 1, new[DEPTH-2..DEPTH-1] = 0.
  - `count` decrements by 2, floored at 0.
  - `underflow` pulses if `count` < 3 before the edge.
- Arithmetic rules:
  - `count` arithmetic is unsigned and saturating; it never wraps.
  - Shifted-in entries are always 0, never stale data.
- On a faulting cycle the data update is still performed exactly as described above; only rotate out of range is suppressed.
- Both fault flags are 0 on any cycle with no fault.

## Timing
- Single-cycle: commands presented in cycle n take effect at the rising edge ending cycle n. Outputs show the new state in cycle n+1.
- `top`, `second`, `third` and `rotate_value` are combinational from the registers. There is no input-to-output combinational path except `rotate_addr` to `rotate_value`.
- `overflow` and `underflow` assert in cycle n+1 for exactly one cycle.
- Asserting `reset` forces the reset values immediately, independent of `clk`, including mid-stream. The first command accepted is on the first rising edge after `reset` deasserts.
- There is no handshake and no back-pressure; `halt` is the only stall.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 (`movement`=01) -> `top`=0x33, `second`=0x22, `third`=0x11, `count`=3, no fault flags.
- From that state, pop 2 with `next_top`=0x55 -> `top`=0x55, `second`=0, `count`=1, `underflow`=0. A following pop 1 with `next_top`=0x66 -> `top`=0x66, `count`=0, `underflow`=1 for one cycle.
- Push 1..5 so that entry0=5 and entry4=1. Set `rotate`=1, `rotate_addr`=3 -> entries read 2,5,4,3,1; `count`=5. Then `rotate_addr`=7 -> entries unchanged, `underflow` pulses.
- Copy: with the stack 2,5,4,3,1, set `rotate_addr`=2 and confirm `rotate_value`=4. Push with `next_top`=4 -> `top`=4, `second`=2, `count`=6.
- Fill to DEPTH=32 with values 1..32, then push 0xAA -> `top`=0xAA, entry31=2 (value 1 lost), `count`=32, `overflow`=1 for one cycle. With `halt`=1 and `movement`=01 -> no change and no flags.
- Assert `reset` mid-cycle between edges during a push sequence -> all outputs 0 immediately, `count`=0.
